// File: rtl/cpri_rx_lane_deskew.sv
// Multi-lane CPRI receive deskew: per-lane FIFOs find the SOP on every lane and
// release all lanes in lockstep, measuring inter-lane skew and flagging errors.
module cpri_rx_lane_deskew #(
    parameter int unsigned LANE  = 8,
    parameter int unsigned DW    = 64,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned TMO   = 1023
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [LANE-1:0][DW-1:0]  i_rx_data,
    input  logic [LANE-1:0]          i_rx_vld,
    input  logic [LANE-1:0]          i_rx_sop,
    output logic [LANE-1:0][DW-1:0]  o_data,
    output logic                     o_vld,
    output logic                     o_sop,
    output logic                     o_locked,
    output logic [7:0]               o_skew,
    output logic                     o_err_tmo,
    output logic                     o_err_ovf,
    output logic                     o_err_align
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = ($clog2(TMO + 1) < 10) ? 10 : $clog2(TMO + 1);
    localparam logic [CW-1:0] TMO_CNT = CW'(TMO);
    localparam logic [CW-1:0] SKEW_MAX = CW'(255);

    typedef enum logic [1:0] {StIdle, StWait, StRun} state_e;

    state_e                 state;
    logic [CW-1:0]          cnt;
    logic [LANE-1:0]        arm;
    logic [AW:0]            wr_ptr [LANE];
    logic [AW:0]            rd_ptr [LANE];
    logic [DW:0]            mem    [LANE][DEPTH];

    logic [LANE-1:0]          empty;
    logic [LANE-1:0]          full;
    logic [LANE-1:0]          head_sop;
    logic [LANE-1:0][DW-1:0]  head_data;
    logic [LANE-1:0]          wr_req;
    logic [LANE-1:0]          wr_en;
    logic [LANE-1:0]          ovf;
    logic [LANE-1:0]          pop;
    logic                     all_ne;
    logic                     all_sop;
    logic                     any_sop;
    logic                     sop_eq;
    logic                     tmo_hit;
    logic                     flush;

    always_comb begin
        for (int l = 0; l < LANE; l++) begin
            empty[l]     = (wr_ptr[l] == rd_ptr[l]);
            full[l]      = (wr_ptr[l][AW-1:0] == rd_ptr[l][AW-1:0]) &&
                           (wr_ptr[l][AW] != rd_ptr[l][AW]);
            head_sop[l]  = mem[l][rd_ptr[l][AW-1:0]][DW];
            head_data[l] = mem[l][rd_ptr[l][AW-1:0]][DW-1:0];
            // Unarmed lanes only accept an SOP word
            wr_req[l]    = i_rx_vld[l] & (arm[l] | i_rx_sop[l]);
        end
    end

    assign all_ne  = &(~empty);
    assign all_sop = all_ne & (&head_sop);
    assign any_sop = |(~empty & head_sop);
    assign sop_eq  = (&head_sop) | ~(|head_sop);

    always_comb begin
        pop = '0;
        unique case (state)
            StWait:  pop = all_sop ? '1 : (~empty & ~head_sop);
            StRun:   pop = (all_ne && sop_eq) ? '1 : '0;
            default: pop = '0;
        endcase
    end

    assign tmo_hit = (state == StWait) && !all_sop && (cnt == TMO_CNT);
    assign ovf     = wr_req & full & ~pop;
    assign flush   = (|ovf) | tmo_hit;
    assign wr_en   = wr_req & (~full | pop) & {LANE{~flush}};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int l = 0; l < LANE; l++) begin
                wr_ptr[l] <= '0;
                rd_ptr[l] <= '0;
            end
        end else begin
            for (int l = 0; l < LANE; l++) begin
                if (flush) begin
                    wr_ptr[l] <= '0;
                    rd_ptr[l] <= '0;
                end else begin
                    if (wr_en[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
                    if (pop[l])   rd_ptr[l] <= rd_ptr[l] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        for (int l = 0; l < LANE; l++) begin
            if (wr_en[l]) mem[l][wr_ptr[l][AW-1:0]] <= {i_rx_sop[l], i_rx_data[l]};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= StIdle;
            cnt         <= '0;
            arm         <= '0;
            o_data      <= '0;
            o_vld       <= 1'b0;
            o_sop       <= 1'b0;
            o_skew      <= '0;
            o_err_tmo   <= 1'b0;
            o_err_ovf   <= 1'b0;
            o_err_align <= 1'b0;
        end else begin
            o_vld       <= 1'b0;
            o_sop       <= 1'b0;
            o_err_tmo   <= 1'b0;
            o_err_ovf   <= 1'b0;
            o_err_align <= 1'b0;
            arm         <= flush ? '0 : (arm | (i_rx_vld & i_rx_sop));
            if (|ovf) begin
                o_err_ovf <= 1'b1;
                state     <= StIdle;
                cnt       <= '0;
            end else if (tmo_hit) begin
                o_err_tmo <= 1'b1;
                state     <= StIdle;
                cnt       <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        // Start at 1 when some lane is still missing, so skew counts
                        // from the cycle the first SOP reached a FIFO head.
                        if (any_sop) begin
                            state <= StWait;
                            cnt   <= all_sop ? '0 : CW'(1);
                        end
                    end
                    StWait: begin
                        if (all_sop) begin
                            o_skew <= (cnt > SKEW_MAX) ? 8'hFF : cnt[7:0];
                            state  <= StRun;
                            o_vld  <= 1'b1;
                            o_sop  <= 1'b1;
                            o_data <= head_data;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    StRun: begin
                        if (all_ne) begin
                            if (sop_eq) begin
                                o_vld  <= 1'b1;
                                o_sop  <= head_sop[0];
                                o_data <= head_data;
                            end else begin
                                o_err_align <= 1'b1;
                                state       <= StWait;
                                cnt         <= '0;
                            end
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign o_locked = (state == StRun);

endmodule

// File: tb/tb_cpri_rx_lane_deskew.sv
// Directed bench for cpri_rx_lane_deskew with an output-beat scoreboard.
module tb_cpri_rx_lane_deskew;

    localparam int LANE  = 8;
    localparam int DW    = 64;
    localparam int DEPTH = 16;
    localparam int TMO   = 1023;

    typedef struct packed {
        logic                    sop;
        logic [LANE-1:0][DW-1:0] data;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [LANE-1:0][DW-1:0] rx_data = '0;
    logic [LANE-1:0]         rx_vld = '0;
    logic [LANE-1:0]         rx_sop = '0;
    logic [LANE-1:0][DW-1:0] o_data;
    logic                    o_vld, o_sop, o_locked, o_err_tmo, o_err_ovf, o_err_align;
    logic [7:0]              o_skew;

    cpri_rx_lane_deskew #(.LANE(LANE), .DW(DW), .DEPTH(DEPTH), .TMO(TMO)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_rx_data   (rx_data),
        .i_rx_vld    (rx_vld),
        .i_rx_sop    (rx_sop),
        .o_data      (o_data),
        .o_vld       (o_vld),
        .o_sop       (o_sop),
        .o_locked    (o_locked),
        .o_skew      (o_skew),
        .o_err_tmo   (o_err_tmo),
        .o_err_ovf   (o_err_ovf),
        .o_err_align (o_err_align)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    beat_t exp_q[$];
    logic [DW:0] lane_q[LANE][$];
    int lane_start[LANE];
    int drv_cyc, sop_cyc, tmo_cyc, ovf_cyc;
    int tmo_cnt, ovf_cnt, align_cnt, vld_total, vld_run, vld_max;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_wide(input string tag, input logic [LANE*DW-1:0] obs,
                              input logic [LANE*DW-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] mk(input int l, input int p, input int w);
        return {8'(l), 8'(p), 16'(w), 32'hA5C3_0000 ^ 32'(l * 977 + p * 131 + w)};
    endfunction

    task automatic add_lane_pkt(input int l, input int p, input int len);
        for (int w = 0; w < len; w++) lane_q[l].push_back({w == 0, mk(l, p, w)});
    endtask

    task automatic add_exp(input int p, input int len);
        beat_t b;
        for (int w = 0; w < len; w++) begin
            b.sop = (w == 0);
            for (int l = 0; l < LANE; l++) b.data[l] = mk(l, p, w);
            exp_q.push_back(b);
        end
    endtask

    task automatic clear_stats();
        tmo_cnt = 0; ovf_cnt = 0; align_cnt = 0;
        vld_total = 0; vld_run = 0; vld_max = 0;
        sop_cyc = -1; tmo_cyc = -1; ovf_cyc = -1; drv_cyc = -1;
        for (int l = 0; l < LANE; l++) lane_start[l] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_vld = '0; rx_sop = '0; rx_data = '0;
        exp_q.delete();
        for (int l = 0; l < LANE; l++) lane_q[l].delete();
        idle(3);
        rst_n = 1'b1;
        clear_stats();
        idle(2);
    endtask

    // Plays the per-lane queues, lane l starting lane_start[l] cycles in.
    // abort_at >= 0 drops reset in the middle of that cycle.
    task automatic run_lanes(input int abort_at);
        int c;
        bit busy;
        bit first;
        logic [DW:0] e;
        c = 0;
        first = 1'b1;
        do begin
            @(posedge clk);
            #1;
            busy = 1'b0;
            for (int l = 0; l < LANE; l++) begin
                if (c >= lane_start[l] && lane_q[l].size() > 0) begin
                    e = lane_q[l].pop_front();
                    rx_vld[l]  = 1'b1;
                    rx_sop[l]  = e[DW];
                    rx_data[l] = e[DW-1:0];
                    if (e[DW] && first) begin
                        drv_cyc = cyc;
                        first = 1'b0;
                    end
                end else begin
                    rx_vld[l] = 1'b0;
                    rx_sop[l] = 1'b0;
                end
                if (lane_q[l].size() > 0) busy = 1'b1;
            end
            if (abort_at >= 0 && c == abort_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_vld", 64'(o_vld), 64'd0);
                check("rst_sop", 64'(o_sop), 64'd0);
                check("rst_locked", 64'(o_locked), 64'd0);
                check_wide("rst_data", o_data, '0);
                rx_vld = '0; rx_sop = '0;
                for (int l = 0; l < LANE; l++) lane_q[l].delete();
                exp_q.delete();
                return;
            end
            c++;
        end while (busy && c < 1000);
        @(posedge clk);
        #1;
        rx_vld = '0;
        rx_sop = '0;
    endtask

    always @(negedge clk) begin
        beat_t b;
        if (o_vld) begin
            vld_total++;
            vld_run++;
            if (vld_run > vld_max) vld_max = vld_run;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 64'(o_vld), 64'd0);
            end else begin
                b = exp_q.pop_front();
                check("beat_sop", 64'(o_sop), 64'(b.sop));
                check_wide("beat_data", o_data, b.data);
            end
        end else begin
            vld_run = 0;
        end
        if (o_sop && sop_cyc < 0) sop_cyc = cyc;
        if (o_err_tmo)   begin tmo_cnt++;   tmo_cyc = cyc; end
        if (o_err_ovf)   begin ovf_cnt++;   ovf_cyc = cyc; end
        if (o_err_align) align_cnt++;
        if (o_err_tmo || o_err_ovf || o_err_align)
            check("one_err_pulse", 64'(o_err_tmo + o_err_ovf + o_err_align), 64'd1);
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clear_stats();
        idle(2);
        // Reset state
        check("reset_vld", 64'(o_vld), 64'd0);
        check("reset_sop", 64'(o_sop), 64'd0);
        check("reset_locked", 64'(o_locked), 64'd0);
        check("reset_skew", 64'(o_skew), 64'd0);
        check("reset_errs", 64'({o_err_tmo, o_err_ovf, o_err_align}), 64'd0);
        check_wide("reset_data", o_data, '0);
        do_reset();

        // Zero skew
        idle(10);
        for (int l = 0; l < LANE; l++) add_lane_pkt(l, 1, 32);
        add_exp(1, 32);
        run_lanes(-1);
        idle(10);
        check("zs_drained", 64'(exp_q.size()), 64'd0);
        check("zs_latency", 64'(sop_cyc - drv_cyc), 64'd3);
        check("zs_run", 64'(vld_max), 64'd32);
        check("zs_total", 64'(vld_total), 64'd32);
        check("zs_skew", 64'(o_skew), 64'd0);
        check("zs_locked", 64'(o_locked), 64'd1);
        check("zs_errs", 64'(tmo_cnt + ovf_cnt + align_cnt), 64'd0);

        // Skew: lane 3 late by 5, lane 6 late by 2
        do_reset();
        lane_start[3] = 5;
        lane_start[6] = 2;
        for (int l = 0; l < LANE; l++) add_lane_pkt(l, 2, 32);
        add_exp(2, 32);
        run_lanes(-1);
        idle(10);
        check("sk_drained", 64'(exp_q.size()), 64'd0);
        check("sk_skew", 64'(o_skew), 64'd5);
        check("sk_total", 64'(vld_total), 64'd32);
        check("sk_locked", 64'(o_locked), 64'd1);
        check("sk_errs", 64'(tmo_cnt + ovf_cnt + align_cnt), 64'd0);

        // Timeout: lane 7 silent
        do_reset();
        for (int l = 0; l < LANE - 1; l++) add_lane_pkt(l, 3, 4);
        run_lanes(-1);
        for (int i = 0; i < 1100 && tmo_cnt == 0; i++) idle(1);
        idle(3);
        check("tmo_count", 64'(tmo_cnt), 64'd1);
        check("tmo_time", 64'(tmo_cyc - drv_cyc), 64'(TMO + 2));
        check("tmo_no_out", 64'(vld_total), 64'd0);
        check("tmo_unlocked", 64'(o_locked), 64'd0);
        for (int l = 0; l < LANE; l++) add_lane_pkt(l, 4, 8);
        add_exp(4, 8);
        run_lanes(-1);
        idle(10);
        check("tmo_relock_drained", 64'(exp_q.size()), 64'd0);
        check("tmo_relock", 64'(o_locked), 64'd1);
        check("tmo_no_ovf", 64'(ovf_cnt + align_cnt), 64'd0);

        // Overflow: lane 2 fed 17 words, others silent
        do_reset();
        add_lane_pkt(2, 5, 17);
        run_lanes(-1);
        idle(5);
        check("ovf_count", 64'(ovf_cnt), 64'd1);
        check("ovf_time", 64'(ovf_cyc - drv_cyc), 64'd17);
        check("ovf_unlocked", 64'(o_locked), 64'd0);
        check("ovf_no_out", 64'(vld_total + tmo_cnt), 64'd0);
        for (int l = 0; l < LANE; l++) add_lane_pkt(l, 6, 8);
        add_exp(6, 8);
        run_lanes(-1);
        idle(10);
        check("ovf_recover_drained", 64'(exp_q.size()), 64'd0);
        check("ovf_recover_locked", 64'(o_locked), 64'd1);

        // Misalignment: lane 4 starts the next packet three words early
        do_reset();
        for (int l = 0; l < LANE; l++) begin
            add_lane_pkt(l, 7, (l == 4) ? 29 : 32);
            add_lane_pkt(l, 8, 32);
        end
        add_exp(7, 29);
        add_exp(8, 32);
        run_lanes(-1);
        idle(10);
        check("mis_align_count", 64'(align_cnt), 64'd1);
        check("mis_drained", 64'(exp_q.size()), 64'd0);
        check("mis_total", 64'(vld_total), 64'd61);
        check("mis_locked", 64'(o_locked), 64'd1);
        check("mis_skew", 64'(o_skew), 64'd3);
        check("mis_other_errs", 64'(tmo_cnt + ovf_cnt), 64'd0);

        // Reset mid-packet at word 10
        do_reset();
        for (int l = 0; l < LANE; l++) add_lane_pkt(l, 9, 32);
        add_exp(9, 32);
        run_lanes(10);
        idle(2);
        rst_n = 1'b1;
        clear_stats();
        idle(3);
        check("rmp_locked_after", 64'(o_locked), 64'd0);
        for (int l = 0; l < LANE; l++) add_lane_pkt(l, 10, 32);
        add_exp(10, 32);
        run_lanes(-1);
        idle(10);
        check("rmp_drained", 64'(exp_q.size()), 64'd0);
        check("rmp_total", 64'(vld_total), 64'd32);
        check("rmp_errs", 64'(tmo_cnt + ovf_cnt + align_cnt), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
